// File: rtl/cca_power_hyst_detect.sv
// cca_power_hyst_detect
// Channel-busy detector for the delayed power stream leaving the xpu delay FIFO.
// Uses two thresholds (hysteresis) and a minimum run length in each direction
// before it changes its decision. It also records how many valid samples each
// completed busy period lasted, so software can read that value back.
module cca_power_hyst_detect #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 6,
  parameter int DUR_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] thr_high,
  input  logic [DATA_WIDTH-1:0] thr_low,
  input  logic [CNT_WIDTH-1:0]  min_busy_len,
  input  logic [CNT_WIDTH-1:0]  min_idle_len,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  ch_busy,
  output logic                  busy_rise,
  output logic                  busy_fall,
  output logic [DUR_WIDTH-1:0]  last_busy_dur
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY_PEND = 2'd1,
    BUSY      = 2'd2,
    IDLE_PEND = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH:0]   RUN_ONE_X = {{CNT_WIDTH{1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] RUN_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] RUN_ZERO  = '0;
  localparam logic [DUR_WIDTH-1:0] DUR_ONE   = {{(DUR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DUR_WIDTH-1:0] DUR_ZERO  = '0;

  state_t                 state;
  logic [CNT_WIDTH-1:0]   run_cnt;
  logic [DUR_WIDTH-1:0]   dur_cnt;

  // The run-length arithmetic uses one extra bit. This keeps the "run_cnt+1"
  // compare free of wrap-around.
  logic [CNT_WIDTH:0]     eb_x, ei_x, run_nxt_x;
  logic                   hi_hit, lo_hit;
  logic                   eb_one, ei_one;
  logic                   busy_done, idle_done;
  logic [DUR_WIDTH-1:0]   dur_sat;

  // Decode this cycle's sample against the live thresholds and lengths.
  always_comb begin
    hi_hit    = (data_in >= thr_high);
    lo_hit    = (data_in <= thr_low);
    eb_x      = (min_busy_len == RUN_ZERO) ? RUN_ONE_X : {1'b0, min_busy_len};
    ei_x      = (min_idle_len == RUN_ZERO) ? RUN_ONE_X : {1'b0, min_idle_len};
    eb_one    = (eb_x == RUN_ONE_X);
    ei_one    = (ei_x == RUN_ONE_X);
    run_nxt_x = {1'b0, run_cnt} + RUN_ONE_X;
    // If a length is lowered in the middle of a run, ">=" ends that run.
    // With stable lengths this behaves exactly like an equality check.
    busy_done = (run_nxt_x >= eb_x);
    idle_done = (run_nxt_x >= ei_x);
    dur_sat   = (&dur_cnt) ? dur_cnt : (dur_cnt + DUR_ONE);
  end

  // Detector FSM with registered flag, pulses and busy-duration capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      run_cnt       <= RUN_ZERO;
      dur_cnt       <= DUR_ZERO;
      ch_busy       <= 1'b0;
      busy_rise     <= 1'b0;
      busy_fall     <= 1'b0;
      last_busy_dur <= DUR_ZERO;
    end else begin
      busy_rise <= 1'b0;
      busy_fall <= 1'b0;
      if (!enable) begin
        // Forced idle. No fall pulse here; the last captured duration is kept.
        state   <= IDLE;
        run_cnt <= RUN_ZERO;
        dur_cnt <= DUR_ZERO;
        ch_busy <= 1'b0;
      end else if (data_in_valid) begin
        unique case (state)
          IDLE: begin
            if (hi_hit) begin
              if (eb_one) begin
                state     <= BUSY;
                ch_busy   <= 1'b1;
                busy_rise <= 1'b1;
                dur_cnt   <= DUR_ONE;
                run_cnt   <= RUN_ZERO;
              end else begin
                state   <= BUSY_PEND;
                run_cnt <= RUN_ONE;
              end
            end
          end
          BUSY_PEND: begin
            if (hi_hit) begin
              if (busy_done) begin
                state     <= BUSY;
                ch_busy   <= 1'b1;
                busy_rise <= 1'b1;
                dur_cnt   <= DUR_ONE;
                run_cnt   <= RUN_ZERO;
              end else begin
                run_cnt <= run_nxt_x[CNT_WIDTH-1:0];
              end
            end else begin
              state   <= IDLE;
              run_cnt <= RUN_ZERO;
            end
          end
          BUSY: begin
            if (lo_hit && ei_one) begin
              state         <= IDLE;
              ch_busy       <= 1'b0;
              busy_fall     <= 1'b1;
              last_busy_dur <= dur_sat;
              dur_cnt       <= DUR_ZERO;
              run_cnt       <= RUN_ZERO;
            end else begin
              dur_cnt <= dur_sat;
              if (lo_hit) begin
                state   <= IDLE_PEND;
                run_cnt <= RUN_ONE;
              end
            end
          end
          IDLE_PEND: begin
            if (lo_hit && idle_done) begin
              state         <= IDLE;
              ch_busy       <= 1'b0;
              busy_fall     <= 1'b1;
              last_busy_dur <= dur_sat;
              dur_cnt       <= DUR_ZERO;
              run_cnt       <= RUN_ZERO;
            end else begin
              dur_cnt <= dur_sat;
              if (lo_hit) begin
                run_cnt <= run_nxt_x[CNT_WIDTH-1:0];
              end else begin
                state   <= BUSY;
                run_cnt <= RUN_ZERO;
              end
            end
          end
          default: begin
            state   <= IDLE;
            run_cnt <= RUN_ZERO;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cca_power_hyst_detect.sv
// Directed bench for cca_power_hyst_detect. A second instance, built with a
// 4-bit duration counter, is used to check saturation.
module tb_cca_power_hyst_detect;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic [7:0] thr_high = 8'd100;
  logic [7:0] thr_low = 8'd60;
  logic [5:0] min_busy_len = 6'd3;
  logic [5:0] min_idle_len = 6'd2;
  logic [7:0] data_in = 8'd0;
  logic       data_in_valid = 1'b0;

  logic        ch_busy, busy_rise, busy_fall;
  logic [15:0] last_busy_dur;
  logic        ch_busy4, busy_rise4, busy_fall4;
  logic [3:0]  last_busy_dur4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cca_power_hyst_detect #(.DATA_WIDTH(8), .CNT_WIDTH(6), .DUR_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .thr_high(thr_high), .thr_low(thr_low),
    .min_busy_len(min_busy_len), .min_idle_len(min_idle_len), .data_in(data_in),
    .data_in_valid(data_in_valid), .ch_busy(ch_busy), .busy_rise(busy_rise),
    .busy_fall(busy_fall), .last_busy_dur(last_busy_dur)
  );

  cca_power_hyst_detect #(.DATA_WIDTH(8), .CNT_WIDTH(6), .DUR_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .enable(enable), .thr_high(thr_high), .thr_low(thr_low),
    .min_busy_len(min_busy_len), .min_idle_len(min_idle_len), .data_in(data_in),
    .data_in_valid(data_in_valid), .ch_busy(ch_busy4), .busy_rise(busy_rise4),
    .busy_fall(busy_fall4), .last_busy_dur(last_busy_dur4)
  );

  // One valid sample. It is driven 1ns after an edge, and the outputs are then
  // observed 1ns after the edge that samples it.
  task automatic sample(input logic [7:0] s);
    data_in = s;
    data_in_valid = 1'b1;
    @(posedge clk); #1;
    data_in_valid = 1'b0;
  endtask

  task automatic idle_cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cfg(input logic [7:0] hi, input logic [7:0] lo, input logic [5:0] mb, input logic [5:0] mi);
    thr_high = hi; thr_low = lo; min_busy_len = mb; min_idle_len = mi;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_cyc(2);
    checks++; if (ch_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", ch_busy); end
    checks++; if ({busy_rise, busy_fall} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b exp=00", {busy_rise, busy_fall}); end
    checks++; if (last_busy_dur !== 16'd0) begin errors++; $display("FAIL reset_dur got=%0d exp=0", last_busy_dur); end
    rst = 1'b0;
    idle_cyc(1);
  endtask

  task automatic test_busy_entry;
    cfg(8'd100, 8'd60, 6'd3, 6'd2);
    sample(8'd120);
    checks++; if (ch_busy !== 1'b0) begin errors++; $display("FAIL entry_s1 busy got=%0b exp=0", ch_busy); end
    sample(8'd120);
    checks++; if (ch_busy !== 1'b0) begin errors++; $display("FAIL entry_s2 busy got=%0b exp=0", ch_busy); end
    sample(8'd120);
    checks++; if ({ch_busy, busy_rise} !== 2'b11) begin errors++; $display("FAIL entry_s3 busy/rise got=%b exp=11", {ch_busy, busy_rise}); end
    idle_cyc(1);
    checks++; if ({ch_busy, busy_rise} !== 2'b10) begin errors++; $display("FAIL entry_pulse_once got=%b exp=10", {ch_busy, busy_rise}); end
    sample(8'd50);
    sample(8'd50);
    checks++; if ({ch_busy, busy_fall} !== 2'b01) begin errors++; $display("FAIL entry_fall got=%b exp=01", {ch_busy, busy_fall}); end
    checks++; if (last_busy_dur !== 16'd3) begin errors++; $display("FAIL entry_dur got=%0d exp=3", last_busy_dur); end
    // Abort a pending run. After that, a full run is needed again.
    sample(8'd120); sample(8'd120); sample(8'd50);
    checks++; if ({ch_busy, busy_rise} !== 2'b00) begin errors++; $display("FAIL abort_busy got=%b exp=00", {ch_busy, busy_rise}); end
    sample(8'd120); sample(8'd120);
    checks++; if (ch_busy !== 1'b0) begin errors++; $display("FAIL restart_pend got=%0b exp=0", ch_busy); end
    sample(8'd120);
    checks++; if ({ch_busy, busy_rise} !== 2'b11) begin errors++; $display("FAIL restart_busy got=%b exp=11", {ch_busy, busy_rise}); end
  endtask

  task automatic test_idle_hyst;
    // Starts in BUSY with a duration of 1.
    sample(8'd50);
    checks++; if ({ch_busy, busy_fall} !== 2'b10) begin errors++; $display("FAIL hyst_s1 got=%b exp=10", {ch_busy, busy_fall}); end
    sample(8'd70);
    checks++; if ({ch_busy, busy_fall} !== 2'b10) begin errors++; $display("FAIL hyst_s2 got=%b exp=10", {ch_busy, busy_fall}); end
    sample(8'd50);
    checks++; if ({ch_busy, busy_fall} !== 2'b10) begin errors++; $display("FAIL hyst_s3 got=%b exp=10", {ch_busy, busy_fall}); end
    sample(8'd50);
    checks++; if ({ch_busy, busy_fall} !== 2'b01) begin errors++; $display("FAIL hyst_s4 got=%b exp=01", {ch_busy, busy_fall}); end
    checks++; if (last_busy_dur !== 16'd5) begin errors++; $display("FAIL hyst_dur got=%0d exp=5", last_busy_dur); end
    sample(8'd120); sample(8'd120); sample(8'd120);
    sample(8'd80);
    checks++; if ({ch_busy, busy_rise, busy_fall} !== 3'b100) begin errors++; $display("FAIL hyst_mid got=%b exp=100", {ch_busy, busy_rise, busy_fall}); end
    sample(8'd50); sample(8'd50);
    checks++; if (last_busy_dur !== 16'd4) begin errors++; $display("FAIL hyst_mid_dur got=%0d exp=4", last_busy_dur); end
  endtask

  task automatic test_min_zero;
    cfg(8'd100, 8'd60, 6'd0, 6'd0);
    sample(8'd99);
    checks++; if (ch_busy !== 1'b0) begin errors++; $display("FAIL zero_below got=%0b exp=0", ch_busy); end
    sample(8'd100);
    checks++; if ({ch_busy, busy_rise} !== 2'b11) begin errors++; $display("FAIL zero_rise got=%b exp=11", {ch_busy, busy_rise}); end
    sample(8'd60);
    checks++; if ({ch_busy, busy_fall} !== 2'b01) begin errors++; $display("FAIL zero_fall got=%b exp=01", {ch_busy, busy_fall}); end
    checks++; if (last_busy_dur !== 16'd2) begin errors++; $display("FAIL zero_dur got=%0d exp=2", last_busy_dur); end
    sample(8'd100); sample(8'd61);
    checks++; if (ch_busy !== 1'b1) begin errors++; $display("FAIL zero_hold got=%0b exp=1", ch_busy); end
    sample(8'd60);
    checks++; if (last_busy_dur !== 16'd3) begin errors++; $display("FAIL zero_dur3 got=%0d exp=3", last_busy_dur); end
  endtask

  task automatic test_gaps;
    cfg(8'd100, 8'd60, 6'd3, 6'd2);
    sample(8'd120); idle_cyc(5);
    sample(8'd120);
    checks++; if (ch_busy !== 1'b0) begin errors++; $display("FAIL gap_s2 got=%0b exp=0", ch_busy); end
    idle_cyc(5);
    checks++; if (ch_busy !== 1'b0) begin errors++; $display("FAIL gap_hold got=%0b exp=0", ch_busy); end
    sample(8'd120);
    checks++; if ({ch_busy, busy_rise} !== 2'b11) begin errors++; $display("FAIL gap_rise got=%b exp=11", {ch_busy, busy_rise}); end
    idle_cyc(5);
    checks++; if ({ch_busy, busy_rise} !== 2'b10) begin errors++; $display("FAIL gap_after_rise got=%b exp=10", {ch_busy, busy_rise}); end
    sample(8'd50); idle_cyc(5);
    sample(8'd50);
    checks++; if ({ch_busy, busy_fall} !== 2'b01) begin errors++; $display("FAIL gap_fall got=%b exp=01", {ch_busy, busy_fall}); end
    idle_cyc(5);
    checks++; if ({busy_fall, last_busy_dur} !== {1'b0, 16'd3}) begin errors++; $display("FAIL gap_dur fall=%0b dur=%0d exp fall=0 dur=3", busy_fall, last_busy_dur); end
  endtask

  task automatic test_saturate;
    cfg(8'd100, 8'd60, 6'd0, 6'd0);
    for (int i = 0; i < 20; i++) sample(8'd200);
    sample(8'd10);
    checks++; if ({busy_fall4, last_busy_dur4} !== {1'b1, 4'd15}) begin errors++; $display("FAIL sat_dur4 fall=%0b dur=%0d exp fall=1 dur=15", busy_fall4, last_busy_dur4); end
    checks++; if (last_busy_dur !== 16'd21) begin errors++; $display("FAIL sat_dur16 got=%0d exp=21", last_busy_dur); end
  endtask

  task automatic test_rst_enable;
    cfg(8'd100, 8'd60, 6'd1, 6'd3);
    sample(8'd120); sample(8'd50);
    checks++; if (ch_busy !== 1'b1) begin errors++; $display("FAIL en_pend got=%0b exp=1", ch_busy); end
    enable = 1'b0;
    idle_cyc(1);
    checks++; if ({ch_busy, busy_fall} !== 2'b00) begin errors++; $display("FAIL en_off got=%b exp=00", {ch_busy, busy_fall}); end
    checks++; if (last_busy_dur !== 16'd21) begin errors++; $display("FAIL en_off_dur got=%0d exp=21", last_busy_dur); end
    enable = 1'b1;
    sample(8'd120);
    checks++; if ({ch_busy, busy_rise} !== 2'b11) begin errors++; $display("FAIL en_restart got=%b exp=11", {ch_busy, busy_rise}); end
    sample(8'd50);
    rst = 1'b1;
    idle_cyc(1);
    checks++; if ({ch_busy, busy_fall} !== 2'b00) begin errors++; $display("FAIL rst_pend got=%b exp=00", {ch_busy, busy_fall}); end
    checks++; if (last_busy_dur !== 16'd0) begin errors++; $display("FAIL rst_dur got=%0d exp=0", last_busy_dur); end
    rst = 1'b0;
    sample(8'd120);
    checks++; if ({ch_busy, busy_rise} !== 2'b11) begin errors++; $display("FAIL rst_restart got=%b exp=11", {ch_busy, busy_rise}); end
  endtask

  initial begin
    test_reset;
    test_busy_entry;
    test_idle_hyst;
    test_min_zero;
    test_gaps;
    test_saturate;
    test_rst_enable;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
